// File: rtl/fft_reorder_buf_if.sv
// rtl/fft_reorder_buf_if.sv - sample streams between FFT core, reorder buffer and downstream consumer
interface fft_reorder_buf_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic signed [DW-1:0] din_r;
    logic signed [DW-1:0] din_i;
    logic                 out_ready;
    logic                 out_valid;
    logic signed [DW-1:0] dout_r;
    logic signed [DW-1:0] dout_i;
    logic [4:0]           out_idx;
    logic                 out_last;
    logic                 ovf;

    modport master (
        output in_valid, din_r, din_i, out_ready,
        input  out_valid, dout_r, dout_i, out_idx, out_last, ovf
    );

    modport slave (
        input  in_valid, din_r, din_i, out_ready,
        output out_valid, dout_r, dout_i, out_idx, out_last, ovf
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// rtl/fft_reorder_buf.sv - ping-pong reorder buffer, bit-reversed to natural order when FFT_REORDER_BITREV_EN is defined
module fft_reorder_buf #(
    parameter int FFT_SIZE = 32,
    parameter int DW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    fft_reorder_buf_if.slave bus
);
    localparam int AW = $clog2(FFT_SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_SIZE - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic          ovf_q, ovf_d;
    logic          wr_en;
    logic          xfer;
    logic          out_valid_c;
    logic [AW-1:0] rd_addr;

    logic signed [DW-1:0] mem_r [2][FFT_SIZE];
    logic signed [DW-1:0] mem_i [2][FFT_SIZE];

    // A write only lands in a bank that is not FULL and a read only drains a FULL bank,
    // so same-cycle write-complete and read-complete always touch different banks.
    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        ovf_d       = ovf_q;
        out_valid_c = (bank_q[rd_sel_q] == FULL);
        wr_en       = bus.in_valid && (bank_q[wr_sel_q] != FULL);
        xfer        = out_valid_c && bus.out_ready;

        if (bus.in_valid && !wr_en) begin
            ovf_d = 1'b1;
        end

        if (wr_en) begin
            if (wr_cnt_q == LAST_ADDR) begin
                bank_d[wr_sel_q] = FULL;
                wr_cnt_d         = '0;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                bank_d[wr_sel_q] = FILLING;
                wr_cnt_d         = wr_cnt_q + AW'(1);
            end
        end

        if (xfer) begin
            if (rd_cnt_q == LAST_ADDR) begin
                bank_d[rd_sel_q] = EMPTY;
                rd_cnt_d         = '0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                rd_cnt_d = rd_cnt_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Sample storage carries no reset; stale contents are unreachable once banks are EMPTY.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_r[wr_sel_q][wr_cnt_q] <= bus.din_r;
            mem_i[wr_sel_q][wr_cnt_q] <= bus.din_i;
        end
    end

`ifdef FFT_REORDER_BITREV_EN
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = a[AW-1-b];
        end
        return r;
    endfunction

    assign rd_addr = bitrev(rd_cnt_q);
`else
    assign rd_addr = rd_cnt_q;
`endif

    assign bus.out_valid = out_valid_c;
    assign bus.dout_r    = out_valid_c ? mem_r[rd_sel_q][rd_addr] : '0;
    assign bus.dout_i    = out_valid_c ? mem_i[rd_sel_q][rd_addr] : '0;
    assign bus.out_idx   = out_valid_c ? rd_cnt_q : '0;
    assign bus.out_last  = out_valid_c && (rd_cnt_q == LAST_ADDR);
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb/tb_fft_reorder_buf.sv - randomized bench for fft_reorder_buf against a frame-queue reference model
module tb_fft_reorder_buf;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_reorder_buf_if #(.DW(DW)) bus ();

    fft_reorder_buf #(.FFT_SIZE(32), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: completed frames wait in pend_q (32 words each, arrival order); part holds the frame being collected.
    logic [31:0] pend_q [$];
    logic [31:0] part [32];
    int          fill   = 0;
    int          rd_pos = 0;
    bit          m_ovf  = 1'b0;
    bit          both_full;
    bit          take;
    int          cyc    = 0;
    logic [31:0] e;

    logic [15:0] sent_r   [$];
    logic [15:0] recv_r   [$];
    logic [4:0]  recv_idx [$];
    bit          recv_last[$];
    int          recv_cyc [$];

    bit          prev_stall = 1'b0;
    logic [15:0] prev_r, prev_i;
    logic [4:0]  prev_idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_addr(input int n);
`ifdef FFT_REORDER_BITREV_EN
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if ((n & (1 << b)) != 0) r |= 1 << (4 - b);
        end
        return r;
`else
        return n;
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend_q.delete();
            fill       = 0;
            rd_pos     = 0;
            m_ovf      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            both_full = (pend_q.size() >= 64);
            take      = (pend_q.size() >= 32) && bus.out_ready;
            if (bus.in_valid) begin
                if (both_full) begin
                    m_ovf = 1'b1;
                end else begin
                    part[fill] = {bus.din_r, bus.din_i};
                    fill++;
                    if (fill == 32) begin
                        for (int k = 0; k < 32; k++) pend_q.push_back(part[k]);
                        fill = 0;
                    end
                end
            end
            if (take) begin
                rd_pos++;
                if (rd_pos == 32) begin
                    repeat (32) void'(pend_q.pop_front());
                    rd_pos = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pend_q.size() >= 32) begin
            e = pend_q[exp_addr(rd_pos)];
            check("out_valid", {31'h0, bus.out_valid}, 32'h1);
            check("dout_r", {16'h0, bus.dout_r}, {16'h0, e[31:16]});
            check("dout_i", {16'h0, bus.dout_i}, {16'h0, e[15:0]});
            check("out_idx", {27'h0, bus.out_idx}, 32'(rd_pos));
            check("out_last", {31'h0, bus.out_last}, {31'h0, rd_pos == 31});
        end else begin
            check("out_valid_idle", {31'h0, bus.out_valid}, 32'h0);
            check("dout_r_idle", {16'h0, bus.dout_r}, 32'h0);
            check("dout_i_idle", {16'h0, bus.dout_i}, 32'h0);
            check("out_idx_idle", {27'h0, bus.out_idx}, 32'h0);
            check("out_last_idle", {31'h0, bus.out_last}, 32'h0);
        end
        check("ovf", {31'h0, bus.ovf}, {31'h0, m_ovf});
        if (prev_stall) begin
            check("stall_r", {16'h0, bus.dout_r}, {16'h0, prev_r});
            check("stall_i", {16'h0, bus.dout_i}, {16'h0, prev_i});
            check("stall_idx", {27'h0, bus.out_idx}, {27'h0, prev_idx});
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_r     = bus.dout_r;
        prev_i     = bus.dout_i;
        prev_idx   = bus.out_idx;
        if (bus.out_valid && bus.out_ready) begin
            recv_r.push_back(bus.dout_r);
            recv_idx.push_back(bus.out_idx);
            recv_last.push_back(bus.out_last);
            recv_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_recv();
        sent_r.delete();
        recv_r.delete();
        recv_idx.delete();
        recv_last.delete();
        recv_cyc.delete();
    endtask

    task automatic send(input int nsamp, input bit ramp, input int gap_pct);
        for (int i = 0; i < nsamp; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.in_valid = 1'b0;
                step();
            end
            bus.in_valid = 1'b1;
            bus.din_r    = ramp ? 16'(i % 32) : 16'($urandom);
            bus.din_i    = 16'($urandom);
            sent_r.push_back(bus.din_r);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic toggle_ready(input int n);
        repeat (n) begin
            bus.out_ready = !bus.out_ready;
            step();
        end
    endtask

    task automatic random_ready(input int n);
        repeat (n) begin
            bus.out_ready = ($urandom_range(99) < 60);
            step();
        end
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (pend_q.size() != 0 && b < budget) begin
            step();
            b++;
        end
        check("drain_left", 32'(pend_q.size()), 32'h0);
    endtask

    task automatic check_ramp_frame(input string tag);
        check({tag, "_count"}, 32'(recv_r.size()), 32'd32);
        for (int n = 0; n < 32; n++) begin
            check({tag, "_r"}, {16'h0, recv_r[n]}, 32'(exp_addr(n)));
            check({tag, "_idx"}, {27'h0, recv_idx[n]}, 32'(n));
            check({tag, "_last"}, {31'h0, recv_last[n]}, {31'h0, n == 31});
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.din_r     = '0;
        bus.din_i     = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        step();
        bus.in_valid = 1'b1;
        step();
        @(negedge clk);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_ovf", {31'h0, bus.ovf}, 32'h0);
        check("rst_out_idx", {27'h0, bus.out_idx}, 32'h0);
        check("rst_dout_r", {16'h0, bus.dout_r}, 32'h0);
        check("rst_out_last", {31'h0, bus.out_last}, 32'h0);
        step();
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        // single ramp frame, latency and order
        clear_recv();
        bus.out_ready = 1'b1;
        send(32, 1'b1, 0);
        @(negedge clk);
        check("latency_valid", {31'h0, bus.out_valid}, 32'h1);
        step();
        drain(100);
        check_ramp_frame("ramp");

        // three back-to-back frames, no bubbles
        do_reset();
        clear_recv();
        bus.out_ready = 1'b1;
        send(96, 1'b0, 0);
        drain(200);
        check("b2b_count", 32'(recv_r.size()), 32'd96);
        check("b2b_span", 32'(recv_cyc[95] - recv_cyc[0]), 32'd95);
        check("b2b_ovf", {31'h0, bus.ovf}, 32'h0);
        for (int n = 0; n < 96; n++) begin
            check("b2b_data", {16'h0, recv_r[n]}, {16'h0, sent_r[32 * (n / 32) + exp_addr(n % 32)]});
        end

        // downstream blocked: third frame dropped
        do_reset();
        clear_recv();
        bus.out_ready = 1'b0;
        send(96, 1'b0, 0);
        step();
        check("blk_ovf", {31'h0, bus.ovf}, 32'h1);
        check("blk_valid", {31'h0, bus.out_valid}, 32'h1);
        bus.out_ready = 1'b1;
        drain(200);
        step();
        check("blk_count", 32'(recv_r.size()), 32'd64);
        for (int n = 0; n < 64; n++) begin
            check("blk_data", {16'h0, recv_r[n]}, {16'h0, sent_r[32 * (n / 32) + exp_addr(n % 32)]});
        end

        // out_ready toggling every cycle
        do_reset();
        clear_recv();
        bus.out_ready = 1'b0;
        fork
            send(32, 1'b1, 0);
            toggle_ready(130);
        join
        bus.out_ready = 1'b1;
        drain(50);
        check_ramp_frame("tog");

        // reset in the middle of a frame
        do_reset();
        clear_recv();
        bus.out_ready = 1'b1;
        send(20, 1'b1, 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.din_r    = 16'h7fff;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'h0, bus.out_valid}, 32'h0);
        step();
        clear_recv();
        send(32, 1'b1, 0);
        drain(100);
        check_ramp_frame("midrst");

        // random gaps and random backpressure
        do_reset();
        clear_recv();
        fork
            send(160, 1'b0, 30);
            random_ready(400);
        join
        bus.out_ready = 1'b1;
        drain(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
